// File: rtl/serial_add_ctrl.sv
// Sequenced wide adder/subtractor: one SLICE-bit ripple slice per clock, LSB slice first,
// with a registered carry between slices and valid/ready handshakes on both sides.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  input  logic                              c_in,
  input  logic                              sub,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  sum,
  output logic                              c_out,
  output logic [$clog2(WIDTH/SLICE)-1:0]    slice_idx
);

  localparam int unsigned NSLICES = WIDTH / SLICE;
  localparam int unsigned IDXW    = $clog2(NSLICES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              in_ready_nxt;
  logic              out_valid_nxt;
  logic              accept;
  logic              last_slice;
  logic              carry;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [SLICE:0]    slice_res;

  assign accept     = in_valid && in_ready;
  assign last_slice = (slice_idx == IDXW'(NSLICES - 1));

  // The single shared adder slice; operands are shifted down so slice k sits at the bottom.
  always_comb begin
    slice_res = {1'b0, a_sh[SLICE-1:0]} + {1'b0, b_sh[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
  end

  // State and handshake-flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Next-state and next handshake flags.
  always_comb begin
    state_nxt     = state;
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end else begin
          in_ready_nxt = 1'b1;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_nxt     = DONE;
          out_valid_nxt = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt    = IDLE;
          in_ready_nxt = 1'b1;
        end else begin
          out_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        in_ready_nxt = 1'b1;
      end
    endcase
  end

  // Operand latch, slice sequencing and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      slice_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh      <= a;
            b_sh      <= sub ? ~b : b;
            carry     <= sub | c_in;
            slice_idx <= '0;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < NSLICES; k++) begin
            if (slice_idx == IDXW'(k)) begin
              sum[k*SLICE +: SLICE] <= slice_res[SLICE-1:0];
            end
          end
          a_sh  <= a_sh >> SLICE;
          b_sh  <= b_sh >> SLICE;
          carry <= slice_res[SLICE];
          if (last_slice) begin
            c_out     <= slice_res[SLICE];
            slice_idx <= '0;
          end else begin
            slice_idx <= slice_idx + IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: 16-bit instance for protocol/corner cases,
// 8-bit instance swept against an integer reference.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
  logic [15:0] a, b, sum;
  logic [1:0]  slice_idx;

  logic        in_valid8, in_ready8, c_in8, sub8, out_valid8, out_ready8, c_out8;
  logic [7:0]  a8, b8, sum8;
  logic [0:0]  slice_idx8;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .slice_idx(slice_idx)
  );

  serial_add_ctrl #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c_in(c_in8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .c_out(c_out8), .slice_idx(slice_idx8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for exactly one accepting edge (caller guarantees IDLE).
  task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input logic ts);
    a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; sub8 = 1'b0;
    step(); step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
    total++; if (slice_idx !== 2'd0) begin bad++; $display("FAIL reset_slice_idx got=%0d exp=0", slice_idx); end
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready8 got=%b exp=1", in_ready8); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ripple();
    int n;
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (n != 4) begin bad++; $display("FAIL ripple_latency got=%0d exp=4", n); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL ripple_sum got=%h exp=0000", sum); end
    total++; if (c_out !== 1'b1) begin bad++; $display("FAIL ripple_c_out got=%b exp=1", c_out); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ripple_drain_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ripple_drain_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_slices();
    launch(16'h1234, 16'h4321, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++; if (slice_idx !== 2'(i)) begin bad++; $display("FAIL slices_idx%0d got=%0d exp=%0d", i, slice_idx, i); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL slices_run_ready%0d got=%b exp=0", i, in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL slices_run_valid%0d got=%b exp=0", i, out_valid); end
      step();
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL slices_done_valid got=%b exp=1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL slices_done_ready got=%b exp=0", in_ready); end
    total++; if (sum !== 16'h5556) begin bad++; $display("FAIL slices_sum got=%h exp=5556", sum); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL slices_c_out got=%b exp=0", c_out); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_sub();
    int n;
    launch(16'h0005, 16'h0007, 1'b1, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (n != 4) begin bad++; $display("FAIL sub_borrow_latency got=%0d exp=4", n); end
    total++; if (sum !== 16'hFFFE) begin bad++; $display("FAIL sub_borrow_sum got=%h exp=fffe", sum); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL sub_borrow_c_out got=%b exp=0", c_out); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    launch(16'h0007, 16'h0005, 1'b0, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (sum !== 16'h0002) begin bad++; $display("FAIL sub_pos_sum got=%h exp=0002", sum); end
    total++; if (c_out !== 1'b1) begin bad++; $display("FAIL sub_pos_c_out got=%b exp=1", c_out); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    for (int i = 0; i < 3; i++) begin
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1;
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b exp=1", i, out_valid); end
      total++; if (sum !== 16'h3333) begin bad++; $display("FAIL bp_sum%0d got=%h exp=3333", i, sum); end
      total++; if (c_out !== 1'b0) begin bad++; $display("FAIL bp_c_out%0d got=%b exp=0", i, c_out); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0; c_in = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_queue got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int n;
    launch(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL rstmid_sum got=%h exp=0000", sum); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL rstmid_c_out got=%b exp=0", c_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    total++; if (slice_idx !== 2'd0) begin bad++; $display("FAIL rstmid_idx got=%0d exp=0", slice_idx); end
    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (n != 4) begin bad++; $display("FAIL rstmid_next_latency got=%0d exp=4", n); end
    total++; if (sum !== 16'h0100) begin bad++; $display("FAIL rstmid_next_sum got=%h exp=0100", sum); end
    total++; if (c_out !== 1'b0) begin bad++; $display("FAIL rstmid_next_c_out got=%b exp=0", c_out); end
    // Reset while DONE with both handshakes asserted must win and not accept.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstprio_valid got=%b exp=0", out_valid); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL rstprio_sum got=%h exp=0000", sum); end
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstprio_no_accept got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int n;
    int exp_int;
    logic [8:0] exp9;
    out_ready8 = 1'b1;
    for (int ia = 0; ia < 256; ia += 17) begin
      for (int ib = 0; ib < 256; ib++) begin
        for (int m = 0; m < 3; m++) begin
          a8 = 8'(ia); b8 = 8'(ib); c_in8 = (m == 1); sub8 = (m == 2);
          in_valid8 = 1'b1;
          n = 0;
          while (in_ready8 !== 1'b1 && n < 10) begin step(); n++; end
          step();
          in_valid8 = 1'b0;
          n = 0;
          while (out_valid8 !== 1'b1 && n < 10) begin step(); n++; end
          if (m == 2) exp_int = ia + (255 - ib) + 1;
          else        exp_int = ia + ib + m;
          exp9 = 9'(exp_int);
          total++;
          if (n != 2) begin
            bad++; $display("FAIL b2b_latency a=%h b=%h m=%0d got=%0d exp=2", 8'(ia), 8'(ib), m, n);
          end
          total++;
          if ({c_out8, sum8} !== exp9) begin
            bad++; $display("FAIL b2b_result a=%h b=%h m=%0d got=%h exp=%h", 8'(ia), 8'(ib), m, {c_out8, sum8}, exp9);
          end
        end
      end
    end
    c_in8 = 1'b0; sub8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ripple();
    test_slices();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
